// File: rtl/add_arbiter.sv
// add_arbiter
// Round-robin scheduler that time-shares a single adder among NREQ requesters.
// For each granted command the adder is cleared for one cycle, enabled for
// ADD_LAT cycles, its result is captured, and the sum/overflow are returned
// on the granted requester's response channel.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester command handshake (ready one-hot)
//   req_in1/req_in2          packed operands, requester i at [32*i +: 32]
//   rsp_valid/rsp_ready      per-requester response handshake (valid one-hot)
//   rsp_sum/rsp_ovf          captured adder result and overflow flags
//   add_in1/add_in2          operands driven to the shared adder
//   add_enable/add_clear     adder controls
//   add_out/add_overflow     adder result inputs
//   busy                     high whenever the scheduler is not idle
//   op_cnt/ovf_cnt           completed operations / those with overflow
module add_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_in1,
  input  logic [32*NREQ-1:0]   req_in2,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_sum,
  output logic [1:0]           rsp_ovf,
  output logic [31:0]          add_in1,
  output logic [31:0]          add_in2,
  output logic                 add_enable,
  output logic                 add_clear,
  input  logic [31:0]          add_out,
  input  logic [1:0]           add_overflow,
  output logic                 busy,
  output logic [31:0]          op_cnt,
  output logic [31:0]          ovf_cnt
);

  localparam int GW = $clog2(NREQ);
  localparam logic [7:0]      LAT_INIT = 8'(ADD_LAT - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   last_grant_reg;
  logic [GW-1:0]   grant_reg;
  logic [31:0]     op1_reg, op2_reg;
  logic [7:0]      lat_cnt_reg;
  logic [31:0]     sum_reg;
  logic [1:0]      ovf_reg;
  logic [31:0]     op_cnt_reg, ovf_cnt_reg;

  logic [GW-1:0]   sel_idx;
  logic            sel_found;
  logic [GW-1:0]   cand;
  logic            rsp_fire;

  logic [31:0]     in1_arr [NREQ];
  logic [31:0]     in2_arr [NREQ];

  // Unpack the flat operand buses into per-requester words.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign in1_arr[gi] = req_in1[32*gi +: 32];
      assign in2_arr[gi] = req_in2[32*gi +: 32];
    end
  endgenerate

  // Round-robin search starting one past the last grant. The candidate index
  // is formed as (last_grant + k) mod NREQ without leaving GW bits, so it
  // works for NREQ values that are not powers of two.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (int'(last_grant_reg) >= NREQ - k) begin
        cand = last_grant_reg - GW'(NREQ - k);
      end else begin
        cand = last_grant_reg + GW'(k);
      end
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign rsp_fire = (state_reg == RESP) && rsp_ready[grant_reg];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sel_found) state_next = CLEAR;
      CLEAR:   state_next = RUN;
      RUN:     if (lat_cnt_reg == 8'd0) state_next = CAPT;
      CAPT:    state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    add_clear  = 1'b0;
    add_enable = 1'b0;
    case (state_reg)
      IDLE:    if (sel_found) req_ready = ONE_HOT0 << sel_idx;
      CLEAR:   add_clear = 1'b1;
      RUN:     add_enable = 1'b1;
      RESP:    rsp_valid = ONE_HOT0 << grant_reg;
      default: ;
    endcase
  end

  // Datapath: operand latch, latency counter, result capture, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= GW'(NREQ - 1);
      grant_reg      <= '0;
      op1_reg        <= '0;
      op2_reg        <= '0;
      lat_cnt_reg    <= '0;
      sum_reg        <= '0;
      ovf_reg        <= '0;
      op_cnt_reg     <= '0;
      ovf_cnt_reg    <= '0;
    end else begin
      if (state_reg == IDLE && sel_found) begin
        op1_reg        <= in1_arr[sel_idx];
        op2_reg        <= in2_arr[sel_idx];
        grant_reg      <= sel_idx;
        last_grant_reg <= sel_idx;
      end
      // Loaded with ADD_LAT-1 so RUN exits after exactly ADD_LAT cycles.
      if (state_reg == CLEAR) begin
        lat_cnt_reg <= LAT_INIT;
      end else if (state_reg == RUN && lat_cnt_reg != 8'd0) begin
        lat_cnt_reg <= lat_cnt_reg - 8'd1;
      end
      if (state_reg == CAPT) begin
        sum_reg <= add_out;
        ovf_reg <= add_overflow;
      end
      if (rsp_fire) begin
        op_cnt_reg <= op_cnt_reg + 32'd1;
        if (ovf_reg != 2'b00) begin
          ovf_cnt_reg <= ovf_cnt_reg + 32'd1;
        end
      end
    end
  end

  assign add_in1 = op1_reg;
  assign add_in2 = op2_reg;
  assign rsp_sum = sum_reg;
  assign rsp_ovf = ovf_reg;
  assign busy    = (state_reg != IDLE);
  assign op_cnt  = op_cnt_reg;
  assign ovf_cnt = ovf_cnt_reg;

endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
Round-robin scheduler that shares one adder datapath (in1/in2/enable/clear -> out/overflow) among NREQ requesters. Each requester uses a valid/ready command channel and a valid/ready response channel. The block sequences the adder for each request (clear, run, capture) and returns the sum and overflow flags to the granted requester. It sits between multiple ICB-attached masters or accelerators and the single adder instance.

Parameters:
NREQ, 4, number of requesters (2..8); grant index width is clog2(NREQ), derived internally.
ADD_LAT, 1, number of cycles add_enable is held high before add_out is sampled (1..255).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  command valid, one bit per requester
req_ready  out  NREQ  command accept, one-hot or zero
req_in1  in  32*NREQ  operand 1; requester i at [32*i+31:32*i]
req_in2  in  32*NREQ  operand 2, same packing
rsp_valid  out  NREQ  response valid, one-hot or zero
rsp_ready  in  NREQ  response accept
rsp_sum  out  32  captured sum; meaningful while any rsp_valid bit is set
rsp_ovf  out  2  captured adder overflow flags
add_in1  out  32  adder operand 1
add_in2  out  32  adder operand 2
add_enable  out  1  adder enable
add_clear  out  1  adder clear
add_out  in  32  adder result
add_overflow  in  2  adder overflow flags
busy  out  1  high in any state other than IDLE
op_cnt  out  32  completed-operation counter
ovf_cnt  out  32  count of completed operations with rsp_ovf != 0

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; last_grant=NREQ-1, so requester 0 has first priority.
  - All outputs 0: req_ready, rsp_valid, add_in1, add_in2, add_enable, add_clear, rsp_sum, rsp_ovf, busy, op_cnt, ovf_cnt.
  - Reset mid-operation discards the in-flight request; no response is issued for it.
- FSM states: IDLE -> CLEAR -> RUN -> CAPT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, select the first set bit searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[sel]=1 combinationally in the same cycle.
  - On that edge: latch the sel operands into internal registers, set grant=sel and last_grant=sel, go to CLEAR.
  - req_ready is 0 in every other state.
- CLEAR: add_clear=1 for exactly one cycle. add_in1/add_in2 are driven from the latched operands and stay stable until the next grant.
- RUN: add_enable=1 for exactly ADD_LAT consecutive cycles, timed by an 8-bit down-counter. Then go to CAPT.
- CAPT: add_enable=0. On the edge, rsp_sum<=add_out and rsp_ovf<=add_overflow. Go to RESP.
- RESP:
  - rsp_valid[grant]=1; rsp_sum and rsp_ovf are held stable.
  - On rsp_ready[grant]=1: go to IDLE, op_cnt+=1, and ovf_cnt+=1 if rsp_ovf!=0. Both counters wrap at 2^32.
  - rsp_ready bits of non-granted requesters are ignored.
- Latency: command accept in cycle T0, rsp_valid first high in cycle T0+ADD_LAT+3. Minimum back-to-back period is ADD_LAT+4 cycles.
- No bypass: a new req_valid present in the same cycle as a response handshake is considered in the following IDLE cycle.
- Requesters must hold req_valid and operands until req_ready. A req_valid that drops before grant is simply not selected.
- busy = (state != IDLE).

Test Plan:
- ADD_LAT=1, req_valid=0001, in1=5, in2=7 -> req_ready=0001 in T0; add_clear high in T1; add_enable high in T2; rsp_valid=0001 with rsp_sum=12 in T4; op_cnt=1 after handshake.
- All req_valid=1111 held, rsp_ready=1111 -> grants in order 0,1,2,3; then req_valid=0101 -> next grants 0 then 2.
- in1=0xFFFFFFFF, in2=1 with the adder model flagging overflow -> rsp_sum=0, rsp_ovf equals the adder flags (non-zero), ovf_cnt=1.
- rsp_ready held 0 for 10 cycles in RESP with req_valid=1111 -> rsp_valid and rsp_sum stable, req_ready=0000, busy=1; releasing rsp_ready returns to IDLE with the next grant one cycle later.
- rst pulsed during RUN -> the next cycle has all outputs 0 and no response for the aborted request; with req_valid=1010 afterwards the first grant goes to requester 1.
- ADD_LAT=3 -> add_enable high exactly 3 consecutive cycles; rsp_valid first high at T6.
